// File: rtl/mac8_pkg.sv
// mac8_pkg: shared types and constants for the MAC8 dot-product sequencer.
//   state_e    - sequencer states (IDLE, RUN, DRAIN, DONE)
//   DOT_W      - width of the signed 4-lane dot product
//   ACC_W      - width of the signed accumulator
//   sat_bound  - saturation value selected by the sign of the overflowing sum
package mac8_pkg;

    localparam int unsigned DOT_W = 18;
    localparam int unsigned ACC_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // neg = 1 when both addends were negative (sum overflowed downward).
    function automatic logic [ACC_W-1:0] sat_bound(input logic neg);
        logic [ACC_W-1:0] bound;
        bound = neg ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return bound;
    endfunction

endpackage

// File: rtl/mac8_dot4.sv
// mac8_dot4: combinational 4-lane dot product, signed bytes of a times
// unsigned bytes of b, summed into a DOT_W-bit signed result.
//   a_i   in  32     four signed bytes
//   b_i   in  32     four unsigned bytes
//   dot_o out DOT_W  sum of the four lane products (never overflows)
module mac8_dot4
    import mac8_pkg::*;
(
    input  logic [31:0]      a_i,
    input  logic [31:0]      b_i,
    output logic [DOT_W-1:0] dot_o
);

    logic signed [DOT_W-1:0] a_x;
    logic signed [DOT_W-1:0] b_x;
    logic signed [DOT_W-1:0] prod;
    logic signed [DOT_W-1:0] sum;

    always_comb begin
        a_x  = '0;
        b_x  = '0;
        prod = '0;
        sum  = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            // a byte is sign-extended, b byte zero-extended, both to DOT_W
            a_x  = {{(DOT_W-8){a_i[8*i+7]}}, a_i[8*i +: 8]};
            b_x  = {{(DOT_W-8){1'b0}}, b_i[8*i +: 8]};
            prod = a_x * b_x;
            sum  = sum + prod;
        end
        dot_o = sum;
    end

endmodule

// File: rtl/mac8_dot_seq.sv
// mac8_dot_seq: command-driven sequencer that streams operand word pairs
// through mac8_dot4 and accumulates the dot products into a private
// 32-bit signed accumulator with a sticky overflow flag.
//   clk_i, rst_ni              clock, async active-low reset
//   flush_i                    synchronous abort, beats every handshake
//   cmd_valid_i/cmd_ready_o    command (cmd_len_i pairs, cmd_init_i start)
//   op_valid_i/op_ready_o      operand pairs op_a_i (signed) / op_b_i (unsigned)
//   res_valid_o/res_ready_i    result res_o with overflow flag res_ovf_o
//   busy_o                     sequencer not idle
// Build option: MAC8_SAT_EN saturates the accumulator on overflow instead
// of wrapping; the overflow flag is set either way.
module mac8_dot_seq
    import mac8_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic [31:0]      cmd_init_i,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    input  logic [31:0]      op_a_i,
    input  logic [31:0]      op_b_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [31:0]      res_o,
    output logic             res_ovf_o,
    output logic             busy_o
);

    state_e            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [DOT_W-1:0]  p_q, p_d;
    logic              p_v_q, p_v_d;

    logic [DOT_W-1:0]  dot;
    logic [ACC_W-1:0]  p_ext;
    logic [ACC_W-1:0]  sum;
    logic              ovf_now;
    logic              cmd_hs;
    logic              op_hs;
    logic              res_hs;

    mac8_dot4 u_dot4 (
        .a_i   (op_a_i),
        .b_i   (op_b_i),
        .dot_o (dot)
    );

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign op_ready_o  = (state_q == ST_RUN);
    assign res_valid_o = (state_q == ST_DONE);
    assign busy_o      = (state_q != ST_IDLE);
    assign res_o       = acc_q;
    assign res_ovf_o   = ovf_q;

    // flush_i masks every handshake so nothing is taken in an abort cycle
    assign cmd_hs = cmd_valid_i & cmd_ready_o & ~flush_i;
    assign op_hs  = op_valid_i  & op_ready_o  & ~flush_i;
    assign res_hs = res_ready_i & res_valid_o & ~flush_i;

    assign p_ext   = {{(ACC_W-DOT_W){p_q[DOT_W-1]}}, p_q};
    assign sum     = acc_q + p_ext;
    // equal-sign addends whose sum changes sign
    assign ovf_now = (acc_q[ACC_W-1] == p_ext[ACC_W-1]) &&
                     (sum[ACC_W-1] != acc_q[ACC_W-1]);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        p_v_d   = 1'b0;

        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            // product registered on the previous handshake lands here; this
            // overlaps RUN (streaming) and DRAIN (last pair)
            if (p_v_q) begin
`ifdef MAC8_SAT_EN
                acc_d = ovf_now ? sat_bound(acc_q[ACC_W-1]) : sum;
`else
                acc_d = sum;
`endif
                ovf_d = ovf_q | ovf_now;
            end

            case (state_q)
                ST_IDLE: begin
                    if (cmd_hs) begin
                        acc_d   = cmd_init_i;
                        ovf_d   = 1'b0;
                        cnt_d   = cmd_len_i;
                        state_d = (cmd_len_i == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (op_hs) begin
                        p_d   = dot;
                        p_v_d = 1'b1;
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == LEN_W'(1)) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    if (res_hs) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            p_q     <= '0;
            p_v_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            p_v_q   <= p_v_d;
        end
    end

endmodule

// File: tb/tb_mac8_dot_seq.sv
// tb_mac8_dot_seq: directed-vector bench for mac8_dot_seq. Expected results
// are queued when each command is issued and popped by a monitor on every
// result handshake; timing and flush/reset behaviour are checked inline.
module tb_mac8_dot_seq;

    localparam int unsigned LEN_W = 16;

`ifdef MAC8_SAT_EN
    localparam logic [31:0] EXP_OVF_RES = 32'h7FFFFFFF;
`else
    localparam logic [31:0] EXP_OVF_RES = 32'h8001F9F4;
`endif

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             flush_i = 1'b0;
    logic             cmd_valid_i = 1'b0;
    logic             cmd_ready_o;
    logic [LEN_W-1:0] cmd_len_i = '0;
    logic [31:0]      cmd_init_i = '0;
    logic             op_valid_i = 1'b0;
    logic             op_ready_o;
    logic [31:0]      op_a_i = '0;
    logic [31:0]      op_b_i = '0;
    logic             res_valid_o;
    logic             res_ready_i = 1'b1;
    logic [31:0]      res_o;
    logic             res_ovf_o;
    logic             busy_o;

    mac8_dot_seq #(.LEN_W(LEN_W)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_len_i   (cmd_len_i),
        .cmd_init_i  (cmd_init_i),
        .op_valid_i  (op_valid_i),
        .op_ready_o  (op_ready_o),
        .op_a_i      (op_a_i),
        .op_b_i      (op_b_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_o       (res_o),
        .res_ovf_o   (res_ovf_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // scoreboard monitor: every result handshake must match the queue head
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_ni && res_valid_o && res_ready_i && !flush_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got 0x%08h, none required", res_o);
            end else begin
                e = exp_q.pop_front();
                check("result", res_o, e.res);
                check("result_ovf", {31'b0, res_ovf_o}, {31'b0, e.ovf});
            end
        end
    end

    task automatic send_cmd(input logic [31:0] init, input logic [LEN_W-1:0] len);
        int n;
        n = 0;
        cmd_valid_i = 1'b1;
        cmd_init_i  = init;
        cmd_len_i   = len;
        @(negedge clk_i);
        while (!cmd_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        if (!cmd_ready_o) timeout("cmd_accept");
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic send_op(input logic [31:0] a, input logic [31:0] b,
                           input bit hold, output bit immediate);
        int n;
        n = 0;
        op_valid_i = 1'b1;
        op_a_i     = a;
        op_b_i     = b;
        @(negedge clk_i);
        immediate = op_ready_o;
        while (!op_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        if (!op_ready_o) timeout("op_accept");
        @(posedge clk_i);
        #1;
        if (!hold) op_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk_i);
        while (!res_valid_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (!res_valid_o) timeout("result_wait");
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit imm;

        // reset values
        repeat (2) @(negedge clk_i);
        check("rst_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);
        check("rst_op_ready",  {31'b0, op_ready_o},  32'd0);
        check("rst_res_valid", {31'b0, res_valid_o}, 32'd0);
        check("rst_res",       res_o,                32'd0);
        check("rst_ovf",       {31'b0, res_ovf_o},   32'd0);
        check("rst_busy",      {31'b0, busy_o},      32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // basic, with 2-cycle latency and back-to-back readiness
        exp_q.push_back('{res: 32'h00000004, ovf: 1'b0});
        send_cmd(32'h0, 16'd1);
        check("t1_op_ready", {31'b0, op_ready_o}, 32'd1);
        send_op(32'h01010101, 32'h01010101, 1'b0, imm);
        @(negedge clk_i);
        check("t1_lat_k1", {31'b0, res_valid_o}, 32'd0);
        @(negedge clk_i);
        check("t1_lat_k2", {31'b0, res_valid_o}, 32'd1);
        @(posedge clk_i);
        #1;
        check("t1_cmd_ready_next", {31'b0, cmd_ready_o}, 32'd1);

        // signed a lanes x unsigned b lanes: 4 * (-1 * 255)
        exp_q.push_back('{res: 32'hFFFFFC04, ovf: 1'b0});
        send_cmd(32'h0, 16'd1);
        send_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, imm);
        wait_done();

        // streaming: 10 + 4 * 24, one pair per cycle
        exp_q.push_back('{res: 32'd106, ovf: 1'b0});
        send_cmd(32'd10, 16'd4);
        for (int i = 0; i < 4; i++) begin
            send_op(32'h02020202, 32'h03030303, (i < 3), imm);
            check("t3_no_bubble", {31'b0, imm}, 32'd1);
        end
        wait_done();

        // positive overflow: 0x7FFFFFF0 + 129540
        exp_q.push_back('{res: EXP_OVF_RES, ovf: 1'b1});
        send_cmd(32'h7FFFFFF0, 16'd1);
        send_op(32'h7F7F7F7F, 32'hFFFFFFFF, 1'b0, imm);
        wait_done();

        // len 0 with result backpressure; ovf must clear on new command
        res_ready_i = 1'b0;
        exp_q.push_back('{res: 32'h12345678, ovf: 1'b0});
        send_cmd(32'h12345678, 16'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("t5_res_valid", {31'b0, res_valid_o}, 32'd1);
            check("t5_res_stable", res_o, 32'h12345678);
            check("t5_ovf_clear", {31'b0, res_ovf_o}, 32'd0);
            check("t5_cmd_ready", {31'b0, cmd_ready_o}, 32'd0);
        end
        @(posedge clk_i);
        #1;
        res_ready_i = 1'b1;
        wait_done();

        // flush with the 2nd operand handshake
        send_cmd(32'h0, 16'd3);
        send_op(32'h01010101, 32'h01010101, 1'b0, imm);
        op_valid_i = 1'b1;
        flush_i    = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i    = 1'b0;
        op_valid_i = 1'b0;
        check("t6_busy", {31'b0, busy_o}, 32'd0);
        check("t6_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);
        check("t6_op_ready", {31'b0, op_ready_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("t6_no_result", {31'b0, res_valid_o}, 32'd0);
        end
        // flush also blocks a command offered in the same cycle
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b1;
        cmd_len_i   = 16'd1;
        flush_i     = 1'b1;
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
        flush_i     = 1'b0;
        check("t6_cmd_blocked", {31'b0, busy_o}, 32'd0);
        exp_q.push_back('{res: 32'h00000004, ovf: 1'b0});
        send_cmd(32'h0, 16'd1);
        send_op(32'h01010101, 32'h01010101, 1'b0, imm);
        wait_done();

        // stall in RUN: -5 + (80 + 30 - 20 - 1280) + 4 = -1191
        exp_q.push_back('{res: 32'hFFFFFB59, ovf: 1'b0});
        send_cmd(32'hFFFFFFFB, 16'd2);
        send_op(32'h80FF0102, 32'h0A141E28, 1'b0, imm);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("t7_stall_ready", {31'b0, op_ready_o}, 32'd1);
            check("t7_stall_no_res", {31'b0, res_valid_o}, 32'd0);
        end
        @(posedge clk_i);
        #1;
        send_op(32'h01010101, 32'h01010101, 1'b0, imm);
        wait_done();

        // asynchronous reset mid-command
        send_cmd(32'h55, 16'd2);
        send_op(32'h01010101, 32'h01010101, 1'b0, imm);
        #2;
        rst_ni = 1'b0;
        #1;
        check("t8_busy", {31'b0, busy_o}, 32'd0);
        check("t8_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);
        check("t8_op_ready", {31'b0, op_ready_o}, 32'd0);
        check("t8_res", res_o, 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("t8_no_result", {31'b0, res_valid_o}, 32'd0);
        end
        @(posedge clk_i);
        #1;
        exp_q.push_back('{res: 32'd28, ovf: 1'b0});
        send_cmd(32'd4, 16'd1);
        send_op(32'h02020202, 32'h03030303, 1'b0, imm);
        wait_done();

        repeat (3) @(posedge clk_i);
        #1;
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
